// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//
// Byte-addressable, big-endian data memory that sits between the ALU address
// output and the write-back data-bus select. Accesses use a Req/Ready
// handshake with a fixed number of wait states. Operands are captured when
// the request is accepted, so upstream may change them while the access runs.
//
// Optional feature macro: DMEM_ERR_CHECK_EN
//   defined   : misaligned (DAddr[1:0]!=0) or out-of-range (DAddr>DEPTH-4)
//               accesses fault. AddrErr=1 with Ready, no write, DataOut=0.
//   undefined : DAddr[1:0] ignored, word index wraps modulo DEPTH/4,
//               AddrErr is always 0.
//
// Parameters
//   DEPTH        memory size in bytes (power of two, multiple of 4)
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//
// Ports
//   CLK      in   clock, all state changes on the rising edge
//   Reset    in   synchronous active-high reset (memory array not cleared)
//   Req      in   access request, sampled only in IDLE
//   mRD      in   read enable, sampled with Req
//   mWR      in   write enable, sampled with Req
//   DAddr    in   byte address, sampled with Req
//   DataIn   in   write data, sampled with Req
//   Ready    out  one-cycle completion pulse
//   DataOut  out  read data, held until the next completed read
//   AddrErr  out  address fault flag, valid only while Ready=1
//   Busy     out  high while an access is in progress (WAIT or RESP)
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
   parameter int unsigned DEPTH       = 128,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Req,
   input  logic        mRD,
   input  logic        mWR,
   input  logic [31:0] DAddr,
   input  logic [31:0] DataIn,
   output logic        Ready,
   output logic [31:0] DataOut,
   output logic        AddrErr,
   output logic        Busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   // First value of the wait counter; unused when there are no wait states.
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [3:0]    cnt;

   // Operands captured at acceptance
   logic          rd_q;
   logic          wr_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;

   // Operands used by the commit: live inputs when committing straight out
   // of IDLE (no wait states), captured copies otherwise.
   logic          op_rd;
   logic          op_wr;
   logic [31:0]   op_addr;
   logic [31:0]   op_data;

   logic [AW-3:0] widx;
   logic          accept;
   logic          commit;
   logic          fault;
   logic          err_q;

   logic [7:0]    mem [DEPTH];

   assign accept = (state == S_IDLE) && Req;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (Req) begin
               state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      Ready   = 1'b0;
      Busy    = 1'b0;
      AddrErr = 1'b0;
      unique case (state)
         S_IDLE: begin
         end
         S_WAIT: begin
            Busy = 1'b1;
         end
         S_RESP: begin
            Ready   = 1'b1;
            Busy    = 1'b1;
            AddrErr = err_q;
         end
         default: begin
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Wait-state counter: loaded on entry to WAIT, counts down to zero
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (Reset) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= CNT_LOAD;
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   // ---------------------------------------------------------------------
   // Operand capture
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (Reset) begin
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         rd_q    <= mRD;
         wr_q    <= mWR;
         addr_q  <= DAddr;
         wdata_q <= DataIn;
      end
   end

   always_comb begin
      if (state == S_IDLE) begin
         op_rd   = mRD;
         op_wr   = mWR;
         op_addr = DAddr;
         op_data = DataIn;
      end else begin
         op_rd   = rd_q;
         op_wr   = wr_q;
         op_addr = addr_q;
         op_data = wdata_q;
      end
   end

   // The commit edge is the one that enters RESP; Reset on that edge wins.
   assign commit = (state_nxt == S_RESP) && !Reset;
   assign widx   = op_addr[AW-1:2];

`ifdef DMEM_ERR_CHECK_EN
   assign fault = (op_rd || op_wr) &&
                  ((op_addr[1:0] != 2'b00) || (op_addr > 32'(DEPTH - 4)));
`else
   // Byte offset and bits above the array are don't-care: the index wraps.
   logic addr_unused;
   assign addr_unused = ^{op_addr[31:AW], op_addr[1:0]};
   assign fault       = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Memory array (not reset, contents survive Reset)
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (commit && op_wr && !fault) begin
         mem[{widx, 2'd0}] <= op_data[31:24];
         mem[{widx, 2'd1}] <= op_data[23:16];
         mem[{widx, 2'd2}] <= op_data[15:8];
         mem[{widx, 2'd3}] <= op_data[7:0];
      end
   end

   // ---------------------------------------------------------------------
   // Read data and error flag, updated on the commit edge
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (Reset) begin
         DataOut <= '0;
         err_q   <= 1'b0;
      end else if (commit) begin
         err_q <= fault;
         if (fault) begin
            DataOut <= '0;
         end else if (op_rd) begin
            // Read together with write returns the word being written.
            DataOut <= op_wr ? op_data
                             : {mem[{widx, 2'd0}], mem[{widx, 2'd1}],
                                mem[{widx, 2'd2}], mem[{widx, 2'd3}]};
         end
      end
   end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

- Byte-addressable, big-endian data memory with a request/ready handshake and a programmable wait-state counter.
- Sits between the ALU address output and the write-back data-bus select.
- DataOut is the memory operand the write-back select places on DB when DBDataSrc=1.
- Operations are multi-cycle. Accesses are latched at acceptance, so upstream operands may change while the access is in progress.

## Interface
Parameters:
- DEPTH, 128: memory size in bytes; power of two, multiple of 4.
- WAIT_CYCLES, 2: wait states between acceptance and response; range 0..15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  1  access request; sampled only in IDLE.
- mRD  in  1  read enable; sampled with Req.
- mWR  in  1  write enable; sampled with Req.
- DAddr  in  32  byte address; sampled with Req.
- DataIn  in  32  write data; sampled with Req.
- Ready  out  1  one-cycle completion pulse.
- DataOut  out  32  read data; held until the next completed read.
- AddrErr  out  1  error flag; valid only while Ready=1.
- Busy  out  1  high in WAIT and RESP.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Req=1 latches mRD, mWR, DAddr and DataIn into internal registers.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
  - Req=0: stay in IDLE.
- WAIT:
  - A 4-bit counter loads WAIT_CYCLES-1 on entry and decrements every cycle.
  - Move to RESP on the edge where the counter equals 0.
- RESP:
  - Ready=1 for exactly this cycle.
  - Unconditional return to IDLE.
- Memory commit happens on the edge that enters RESP:
  - Write: mem[a]=DataIn[31:24], mem[a+1]=[23:16], mem[a+2]=[15:8], mem[a+3]=[7:0].
  - Read: DataOut={mem[a],mem[a+1],mem[a+2],mem[a+3]}.
- mRD=1 and mWR=1 together: the write commits, and DataOut takes the newly written word.
- mRD=0 and mWR=0: the access completes with a Ready pulse, memory and DataOut are unchanged, AddrErr=0.
- Req while Busy is ignored and is not queued. Upstream must re-assert Req after seeing Ready.
- Memory array is not reset. Contents persist across Reset.

## Timing
- Reset values: Ready=0, DataOut=32'h0, AddrErr=0, Busy=0, state=IDLE, counter=0.
- Request accepted at edge t: Ready is high during cycle t+WAIT_CYCLES+1, and DataOut is valid from that same cycle.
- Throughput: one access per WAIT_CYCLES+2 cycles. The earliest next acceptance is the edge after RESP.
- Reset asserted in WAIT: the access is aborted, no write commits, and the next state is IDLE.
- Reset asserted on the edge that would enter RESP: Reset wins, and no commit and no Ready occur.
- Latched operands are immune to input changes after acceptance.

## Configuration
- DMEM_ERR_CHECK_EN defined:
  - An access faults when DAddr[1:0]!=0 or DAddr>DEPTH-4.
  - On a faulting access, AddrErr=1 with Ready, no memory write occurs, and DataOut is forced to 32'h0.
  - Latency is unchanged.
- DMEM_ERR_CHECK_EN undefined:
  - DAddr[1:0] is treated as 0, and the word index wraps modulo DEPTH/4.
  - AddrErr is tied to 0.

## Test plan
- Reset, then idle 5 cycles -> Ready=0, DataOut=0, Busy=0 throughout.
- Write 32'h1234ABCD to DAddr=8, then read DAddr=8 with WAIT_CYCLES=2 -> Ready exactly 3 cycles after each acceptance; DataOut=32'h1234ABCD; byte 8 holds 8'h12 and byte 11 holds 8'hCD.
- Req held high continuously for 12 cycles, mRD=1 -> exactly 3 accepted accesses (one per 4 cycles); requests during Busy are dropped.
- Write DAddr=4 then Reset during WAIT -> no Ready; a later read of DAddr=4 returns the prior contents.
- With DMEM_ERR_CHECK_EN, write DAddr=6 -> AddrErr=1 with Ready, and bytes 4..7 are unchanged. Without the macro -> word 4 is written, AddrErr=0.
- WAIT_CYCLES=0 build, read DAddr=0 after writing 32'hFFFF0001 -> Ready in the cycle after acceptance with DataOut=32'hFFFF0001.
